// File: rtl/mdu_e_if.sv
// E-stage multiply/divide unit bus: operand/command inputs and HI/LO/busy outputs.
interface mdu_e_if;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output valid, op, A, B,
    input  busy, start, hi, lo
  );

  modport slave (
    input  valid, op, A, B,
    output busy, start, hi, lo
  );
endinterface

// File: rtl/mdu_e.sv
// MIPS E-stage multiply/divide unit: multi-cycle mult/div into private HI/LO,
// single-cycle mthi/mtlo, busy exported to the stall unit.
module mdu_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  mdu_e_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;
  logic [31:0]       stg_hi;
  logic [31:0]       stg_lo;
  logic              stg_wr;

  logic              is_launch;
  logic              is_mult;
  logic [63:0]       prod_s;
  logic [63:0]       prod_u;
  logic              div_zero;
  logic              div_ovf;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]       b_u;
  logic [31:0]       q_u;
  logic [31:0]       r_u;
  logic [31:0]       res_hi;
  logic [31:0]       res_lo;
  logic              res_wr;

  assign is_launch = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign is_mult   = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign bus.start = bus.valid & ~busy_q & is_launch;

  // Result datapath; divisor is forced to 1 in the zero/overflow cases so the
  // dividers never see an undefined operation, and those cases are overridden.
  always_comb begin
    prod_s   = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u   = {32'd0, bus.A} * {32'd0, bus.B};
    div_zero = (bus.B == 32'd0);
    div_ovf  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    a_s      = $signed(bus.A);
    b_s      = (div_zero || div_ovf) ? 32'sd1 : $signed(bus.B);
    q_s      = a_s / b_s;
    r_s      = a_s % b_s;
    b_u      = div_zero ? 32'd1 : bus.B;
    q_u      = bus.A / b_u;
    r_u      = bus.A % b_u;

    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (bus.op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      OP_DIV: begin
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = 32'(r_s);
          res_lo = 32'(q_s);
        end
        res_wr = ~div_zero;
      end
      OP_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
        res_wr = ~div_zero;
      end
      default: ;
    endcase
  end

  // Control FSM, staging and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      stg_hi <= 32'd0;
      stg_lo <= 32'd0;
      stg_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            if (is_launch) begin
              stg_hi <= res_hi;
              stg_lo <= res_lo;
              stg_wr <= res_wr;
              cnt    <= is_mult ? MULT_LOAD : DIV_LOAD;
              busy_q <= 1'b1;
              state  <= RUN;
            end else if (bus.op == OP_MTHI) begin
              hi_q <= bus.A;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end
        RUN: begin
          if (cnt == '0) begin
            if (stg_wr) begin
              hi_q <= stg_hi;
              lo_q <= stg_lo;
            end
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Directed bench for mdu_e: mult/div results, busy length, operand capture,
// ignored ops while busy, mthi/mtlo and asynchronous reset abort.
`timescale 1ns/1ps
module tb_mdu_e;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mdu_e_if bus ();

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.valid = v;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
  endtask

  // Launch edge then idle inputs.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, o, a, b);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // Counts busy cycles (bounded) and flags any HI/LO movement while busy.
  task automatic wait_busy(output int n, output bit moved);
    logic [31:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    n = 0;
    moved = 1'b0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.hi !== h0 || bus.lo !== l0) moved = 1'b1;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    reset = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.hi, bus.lo} !== 65'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int n; bit moved;
    drive(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
    #1;
    checks++;
    if (bus.start !== 1'b1) begin errors++; $display("FAIL mult_start: got %b expected 1", bus.start); end
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    wait_busy(n, moved);
    checks++;
    if (n != 5) begin errors++; $display("FAIL mult_busy_len: got %0d expected 5", n); end
    checks++;
    if (moved) begin errors++; $display("FAIL mult_early_write: hi/lo changed before completion edge"); end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_result: hi=%h lo=%h expected ffffffff/fffffffa", bus.hi, bus.lo);
    end
  endtask

  task automatic test_multu_div();
    int n; bit moved;
    launch(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_busy(n, moved);
    checks++;
    if (n != 5 || bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL multu: n=%0d hi=%h lo=%h expected 5/00000001/fffffffe", n, bus.hi, bus.lo);
    end
    launch(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_busy(n, moved);
    checks++;
    if (n != 10 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg: n=%0d hi=%h lo=%h expected 10/ffffffff/fffffffd", n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_corner();
    int n; bit moved;
    launch(3'd5, 32'd5, 32'd0);
    launch(3'd6, 32'd6, 32'd0);
    launch(3'd4, 32'd100, 32'd0);
    wait_busy(n, moved);
    checks++;
    if (n != 10 || moved || bus.hi !== 32'd5 || bus.lo !== 32'd6) begin
      errors++; $display("FAIL divu_by_zero: n=%0d moved=%b hi=%h lo=%h expected 10/0/5/6", n, moved, bus.hi, bus.lo);
    end
    launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(n, moved);
    checks++;
    if (n != 10 || bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow: n=%0d hi=%h lo=%h expected 10/0/80000000", n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_capture_back_to_back();
    int n; bit moved; bit start_seen;
    logic [31:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    launch(3'd3, 32'd100, 32'd7);
    n = 0; moved = 1'b0; start_seen = 1'b0;
    // Keep a competing mult on the bus with new operands every cycle.
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.hi !== h0 || bus.lo !== l0) moved = 1'b1;
      drive(1'b1, 3'd1, 32'(n * 3 + 1), 32'(n + 9));
      #1;
      if (bus.start !== 1'b0) start_seen = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n != 10 || moved || start_seen) begin
      errors++; $display("FAIL ignore_while_busy: n=%0d moved=%b start=%b expected 10/0/0", n, moved, start_seen);
    end
    checks++;
    if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
      errors++; $display("FAIL div_captured: hi=%h lo=%h expected 00000002/0000000e", bus.hi, bus.lo);
    end
    drive(1'b1, 3'd1, 32'd6, 32'd7);
    #1;
    checks++;
    if (bus.start !== 1'b1) begin errors++; $display("FAIL b2b_start: got %b expected 1", bus.start); end
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b expected 1", bus.busy); end
    wait_busy(n, moved);
    checks++;
    if (n != 5 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      errors++; $display("FAIL b2b_result: n=%0d hi=%h lo=%h expected 5/0/0000002a", n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    int n; bit moved;
    drive(1'b1, 3'd5, 32'h1234_5678, 32'd0);
    tick();
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mthi: hi=%h busy=%b expected 12345678/0", bus.hi, bus.busy);
    end
    drive(1'b1, 3'd6, 32'h9ABC_DEF0, 32'd0);
    tick();
    checks++;
    if (bus.lo !== 32'h9ABC_DEF0 || bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mtlo: hi=%h lo=%h busy=%b expected 12345678/9abcdef0/0", bus.hi, bus.lo, bus.busy);
    end
    launch(3'd1, 32'd3, 32'd4);
    drive(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd0);
    tick();
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    checks++;
    if (bus.lo !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL mtlo_busy: lo=%h expected 9abcdef0", bus.lo);
    end
    wait_busy(n, moved);
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
      errors++; $display("FAIL mult_after_mtlo: hi=%h lo=%h expected 0/0000000c", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_abort();
    bit late;
    launch(3'd5, 32'h0000_0011, 32'd0);
    launch(3'd3, 32'd50, 32'd5);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++; $display("FAIL reset_abort: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    late = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) late = 1'b1;
    end
    checks++;
    if (late) begin
      errors++; $display("FAIL late_commit: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_div();
    test_div_corner();
    test_capture_back_to_back();
    test_mthi_mtlo();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
